mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//   Shares one unified instruction/data memory port between the fetch stage and the load/store path.
//   The load/store path is driven by the control unit's MemWrite/ResultSrc/AddressingControl outputs.
//   Multi-cycle, fixed-latency accesses; data requests have priority over fetch, with an anti-starvation streak limit.
//   Sits between the core (fetch + LSU) and the memory; exports a stall for the pipeline.
// PARAMETERS
//   ADDR_WIDTH  32  byte address width
//   DATA_WIDTH  32  memory data width
//   LATENCY     2   memory cycles per access (>=1)
//   STREAK_MAX  4   max consecutive data grants while fetch waits (>=1)
// PORTS
//   clk        in   1           clock, rising edge
//   rst        in   1           synchronous, active-high reset
//   if_req     in   1           fetch request; held with if_addr stable until if_done
//   if_addr    in   ADDR_WIDTH  fetch address
//   if_flush   in   1           cancel the outstanding fetch (taken branch/jump)
//   if_done    out  1           1-cycle pulse: fetch complete, if_rdata valid
//   if_rdata   out  DATA_WIDTH  fetched instruction (registered)
//   d_req      in   1           data request; held stable until d_done
//   d_we       in   1           1 = store, 0 = load
//   d_addr     in   ADDR_WIDTH  data address
//   d_wdata    in   DATA_WIDTH  store data
//   d_size     in   3           funct3 addressing code (lb/lh/lw/lbu/lhu, sb/sh/sw), passed through unmodified
//   d_done     out  1           1-cycle pulse: data access complete, d_rdata valid for loads
//   d_rdata    out  DATA_WIDTH  load data (registered)
//   mem_en     out  1           port access active
//   mem_we     out  1           write strobe
//   mem_addr   out  ADDR_WIDTH  latched access address
//   mem_wdata  out  DATA_WIDTH  latched store data
//   mem_size   out  3           latched size code (fetch uses 3'b010)
//   mem_rdata  in   DATA_WIDTH  read data; valid in the last busy cycle
//   stall      out  1           (if_req & ~if_done) | (d_req & ~d_done)
// BEHAVIOUR
//   Reset: state=IDLE, cnt=0, streak=0; all outputs 0, including registered rdata and the latched mem_* fields.
//   States: IDLE, BUSY_IF, BUSY_D.
//   IDLE arbitration (per edge), using masked requests:
//   - A requester whose done is high this cycle is masked; no re-grant on a stale req.
//   - Data is granted if it is requesting, unless if_req is high and streak==STREAK_MAX.
//   - Otherwise fetch is granted if if_req is high.
//   - Grant latches addr/wdata/we/size into the mem_* registers, sets cnt=0 and enters BUSY_x.
//   - A data grant with if_req high increments streak. A fetch grant, or any data grant with if_req low, clears streak.
//   BUSY_x:
//   - mem_en=1 for every cycle of BUSY_x.
//   - mem_we=1 only in the last busy cycle (cnt==LATENCY-1), and only for a data store.
//   - While cnt<LATENCY-1, cnt increments each edge.
//   - At cnt==LATENCY-1 the edge captures mem_rdata into x_rdata, pulses x_done for the next cycle and returns to IDLE.
//   - Stores leave d_rdata unchanged.
//   Latency: req first high in cycle 0 with the port idle -> done high in cycle LATENCY+1. Next grant is possible in the done cycle (other requester only).
//   if_flush:
//   - High in IDLE with no grant: no effect.
//   - High during BUSY_IF, or in the edge of grant: the sticky flag kill is set.
//   - The access still completes; if_done is suppressed and if_rdata is not updated; kill clears on return to IDLE.
//   - if_flush never affects a data access.
//   Simultaneous if_req & d_req in IDLE: data wins (subject to streak).
//   rst mid-access: access abandoned, no done pulse, mem_we never asserted; all state returns to reset values.
//   Address/size are not checked or aligned here; misalignment is the LSU's responsibility.
// TESTING (LATENCY=2, STREAK_MAX=2 unless noted)
//   1. Fetch only: if_req=1, if_addr=0x100 in cycle 0, mem_rdata=0x00500093 in cycle 2.
//      -> mem_en in cycles 1-2, if_done in cycle 3, if_rdata=0x00500093.
//   2. Store: d_req=1, d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF, d_size=3'b010.
//      -> mem_we only in cycle 2, d_done in cycle 3, d_rdata unchanged.
//   3. if_req and d_req both high at cycle 0 -> data served first (d_done cycle 3); fetch granted in cycle 3, if_done cycle 6.
//   4. if_req held high and d_req re-asserted back-to-back -> after 2 data grants the fetch is granted; streak resets to 0.
//   5. if_flush pulsed in cycle 1 of a fetch -> no if_done, if_rdata unchanged, port IDLE in cycle 3, next fetch served normally.
//   6. rst asserted in cycle 2 of a store -> mem_we never high, no d_done; all outputs 0 in the next cycle.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the load/store path.
// Accesses take a fixed LATENCY cycles. Data wins arbitration, but a streak limit keeps fetch from starving.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 2,
  parameter int STREAK_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  input  logic                  if_flush,
  output logic                  if_done,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  input  logic [2:0]            d_size,
  output logic                  d_done,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [2:0]            mem_size,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  stall
);

  localparam int CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int STREAK_W = $clog2(STREAK_MAX + 1);
  localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(LATENCY - 1);
  localparam logic [STREAK_W-1:0] STREAK_TOP = STREAK_W'(STREAK_MAX);
  localparam logic [2:0]          FETCH_SIZE = 3'b010;

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D} state_t;

  state_t                state_reg, state_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic [STREAK_W-1:0]   streak_reg, streak_next;
  logic                  kill_reg, kill_next;
  logic                  acc_we_reg, acc_we_next;
  logic [ADDR_WIDTH-1:0] mem_addr_reg, mem_addr_next;
  logic [DATA_WIDTH-1:0] mem_wdata_reg, mem_wdata_next;
  logic [2:0]            mem_size_reg, mem_size_next;
  logic                  if_done_reg, if_done_next;
  logic                  d_done_reg, d_done_next;
  logic [DATA_WIDTH-1:0] if_rdata_reg, if_rdata_next;
  logic [DATA_WIDTH-1:0] d_rdata_reg, d_rdata_next;

  logic if_req_m, d_req_m, grant_d, grant_if, last_cycle, kill_now;

  // A requester completing this cycle still shows its old req; mask it so it is not re-granted.
  assign if_req_m   = if_req & ~if_done_reg;
  assign d_req_m    = d_req & ~d_done_reg;
  assign grant_d    = (state_reg == IDLE) & d_req_m & ~(if_req_m & (streak_reg == STREAK_TOP));
  assign grant_if   = (state_reg == IDLE) & ~grant_d & if_req_m;
  assign last_cycle = (cnt_reg == CNT_LAST);
  assign kill_now   = kill_reg | if_flush;

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    streak_next    = streak_reg;
    kill_next      = kill_reg;
    acc_we_next    = acc_we_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    mem_size_next  = mem_size_reg;
    if_done_next   = 1'b0;
    d_done_next    = 1'b0;
    if_rdata_next  = if_rdata_reg;
    d_rdata_next   = d_rdata_reg;
    case (state_reg)
      IDLE: begin
        if (grant_d) begin
          state_next     = BUSY_D;
          cnt_next       = '0;
          acc_we_next    = d_we;
          mem_addr_next  = d_addr;
          mem_wdata_next = d_wdata;
          mem_size_next  = d_size;
          streak_next    = if_req_m ? streak_reg + STREAK_W'(1) : '0;
        end else if (grant_if) begin
          state_next    = BUSY_IF;
          cnt_next      = '0;
          acc_we_next   = 1'b0;
          mem_addr_next = if_addr;
          mem_size_next = FETCH_SIZE;
          streak_next   = '0;
          kill_next     = if_flush;
        end
      end
      BUSY_IF: begin
        kill_next = kill_now;
        if (last_cycle) begin
          state_next = IDLE;
          kill_next  = 1'b0;
          if (!kill_now) begin
            if_done_next  = 1'b1;
            if_rdata_next = mem_rdata;
          end
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      BUSY_D: begin
        if (last_cycle) begin
          state_next  = IDLE;
          d_done_next = 1'b1;
          if (!acc_we_reg) d_rdata_next = mem_rdata;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      streak_reg    <= '0;
      kill_reg      <= 1'b0;
      acc_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      mem_size_reg  <= '0;
      if_done_reg   <= 1'b0;
      d_done_reg    <= 1'b0;
      if_rdata_reg  <= '0;
      d_rdata_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      streak_reg    <= streak_next;
      kill_reg      <= kill_next;
      acc_we_reg    <= acc_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      mem_size_reg  <= mem_size_next;
      if_done_reg   <= if_done_next;
      d_done_reg    <= d_done_next;
      if_rdata_reg  <= if_rdata_next;
      d_rdata_reg   <= d_rdata_next;
    end
  end

  // The write strobe is gated by rst so a reset landing on the last busy cycle never commits the store.
  assign mem_we    = (state_reg == BUSY_D) & last_cycle & acc_we_reg & ~rst;
  assign mem_en    = (state_reg != IDLE);
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign mem_size  = mem_size_reg;
  assign if_done   = if_done_reg;
  assign d_done    = d_done_reg;
  assign if_rdata  = if_rdata_reg;
  assign d_rdata   = d_rdata_reg;
  assign stall     = (if_req & ~if_done_reg) | (d_req & ~d_done_reg);

endmodule
